universal_counter_reg: RTL and testbench
========================================

Name: universal_counter_reg

Overview:
- Parametrised N-bit universal counter/shift register.
- Successor to the single-bit universal counter cell: keeps the cell's hold / count-up / count-down / parallel-load mode semantics.
- Adds programmable modulus, shift/rotate modes, serial I/O, count enable, cascade terminal-count output and a registered wrap flag.
- Used as a prescaler, timer or shift stage; cascadable via tc_out -> cnt_en of the next stage.

Parameters:
WIDTH, 8, register width in bits (>=2).
MODULUS, 0, count modulus; 0 means 2^WIDTH; otherwise 2..2^WIDTH, count range 0..MODULUS-1.

Ports:
clk  in  1  rising-edge clock.
rst  in  1  synchronous active-high reset.
mode  in  3  operation select (see Behaviour).
cnt_en  in  1  count enable / cascade input; gates up/down counting only.
d  in  WIDTH  parallel load data.
ser_in  in  1  serial input for shift modes.
q  out  WIDTH  register value.
tc_out  out  1  combinational terminal count (cascade carry/borrow).
ser_out  out  1  combinational serial output.
wrap  out  1  registered one-cycle pulse, high the cycle after a count wrapped.

Behaviour:
- Single clock domain; one clock, synchronous active-high reset. All state updates on rising clk.
- rst=1 at an edge: q<=0, wrap<=0, regardless of mode/cnt_en. Reset has priority mid-operation.
- Let MAX = (MODULUS==0) ? 2^WIDTH-1 : MODULUS-1.
- mode encoding (mode[1:0] matches the bit-cell encoding):
  - 000: hold, q unchanged.
  - 001: count up. If cnt_en=1: q<=0 when q>=MAX, else q+1. If cnt_en=0: hold.
  - 010: count down. If cnt_en=1: q<=MAX when q==0, else q-1. If cnt_en=0: hold.
  - 011: parallel load, q<=d unconditionally (ignores cnt_en). d>MAX is loaded as-is; the next up-count wraps to 0.
  - 100: shift left, q<={q[WIDTH-2:0], ser_in}.
  - 101: shift right, q<={ser_in, q[WIDTH-1:1]}.
  - 110: rotate left, q<={q[WIDTH-2:0], q[WIDTH-1]}.
  - 111: rotate right, q<={q[0], q[WIDTH-1:1]}.
- Shift/rotate ignore cnt_en and MODULUS; the result may exceed MAX (handled as for load).
- tc_out (combinational):
  - mode=001: tc_out = cnt_en & (q>=MAX).
  - mode=010: tc_out = cnt_en & (q==0).
  - All other modes: tc_out = 0.
- wrap: registered copy of tc_out (wrap<=tc_out each non-reset edge). Exactly one cycle high per wrap event.
- ser_out:
  - q[WIDTH-1] in modes 100 and 110.
  - q[0] in modes 101 and 111.
  - 0 otherwise.
- Mode may change every cycle; the decision uses mode and q sampled at the same edge, with no pipeline. Latency from any input to q is 1 cycle.
- Cascading: chaining stage k tc_out into stage k+1 cnt_en, with all stages in the same count mode, yields a correct multi-stage counter with the same single-cycle update.
- No X-propagation from unused inputs: d is ignored outside load, ser_in ignored outside 100/101.

Test Plan:
- Reset: WIDTH=8, run mode=001 cnt_en=1 for 5 cycles, assert rst one cycle -> q=0x00, wrap=0 next cycle; rst asserted during mode=011 d=0xAA -> q=0x00.
- Up wrap, MODULUS=0: load 0xFE, then mode=001 cnt_en=1 -> q=0xFF with tc_out=1, next q=0x00 with wrap=1 for exactly one cycle; cnt_en=0 -> q holds, tc_out=0.
- Down wrap, MODULUS=10: load 0x01, mode=010 cnt_en=1 -> q=0, tc_out=1, then q=9, wrap=1; load d=12 then mode=001 -> q=0.
- Shift/rotate, WIDTH=8: load 0x81, mode=100 ser_in=0 -> q=0x02 and ser_out was 1 before the edge; mode=111 from 0x01 -> q=0x80; mode=101 ser_in=1 from 0x00 -> q=0x80.
- Cascade: two WIDTH=4 instances, stage0 tc_out -> stage1 cnt_en, both mode=001 from 0x0F/0x0 -> stage1=1, stage0=0 in a single edge; 256 cycles -> both return to 0, stage1 tc_out high only at 0xFF.
- Mode churn: alternate 001/010 each cycle with cnt_en=1 from q=5 -> q toggles 6,5,6,5; mode=011 with cnt_en=0 still loads d.

Source files
------------

// File: rtl/universal_counter_reg.sv
// N-bit universal counter / shift register: hold, modulo up/down count, parallel load,
// shift and rotate, with a cascade terminal count and a registered wrap pulse.
module universal_counter_reg #(
  parameter int WIDTH   = 8,
  parameter int MODULUS = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       mode,
  input  logic             cnt_en,
  input  logic [WIDTH-1:0] d,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q,
  output logic             tc_out,
  output logic             ser_out,
  output logic             wrap
);

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_UP   = 3'b001,
    MODE_DOWN = 3'b010,
    MODE_LOAD = 3'b011,
    MODE_SHL  = 3'b100,
    MODE_SHR  = 3'b101,
    MODE_ROL  = 3'b110,
    MODE_ROR  = 3'b111
  } mode_e;

  // MODULUS of 0 selects the full binary range of the register.
  localparam logic [WIDTH-1:0] MAX = (MODULUS == 0) ? {WIDTH{1'b1}} : WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;
  logic [WIDTH-1:0] w_q_next;
  logic             w_tc;
  logic             w_ser;
  logic             w_at_max;
  logic             w_at_zero;
  mode_e            w_mode;

  assign w_mode    = mode_e'(mode);
  // ">=" rather than "==" so values loaded or shifted above MAX still wrap to 0.
  assign w_at_max  = (r_q >= MAX);
  assign w_at_zero = (r_q == '0);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_q_next = r_q;
    w_tc     = 1'b0;
    w_ser    = 1'b0;
    case (w_mode)
      MODE_HOLD: w_q_next = r_q;
      MODE_UP: begin
        w_tc = cnt_en & w_at_max;
        if (cnt_en) w_q_next = w_at_max ? '0 : r_q + ONE;
      end
      MODE_DOWN: begin
        w_tc = cnt_en & w_at_zero;
        if (cnt_en) w_q_next = w_at_zero ? MAX : r_q - ONE;
      end
      MODE_LOAD: w_q_next = d;
      MODE_SHL: begin
        w_q_next = {r_q[WIDTH-2:0], ser_in};
        w_ser    = r_q[WIDTH-1];
      end
      MODE_SHR: begin
        w_q_next = {ser_in, r_q[WIDTH-1:1]};
        w_ser    = r_q[0];
      end
      MODE_ROL: begin
        w_q_next = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
        w_ser    = r_q[WIDTH-1];
      end
      MODE_ROR: begin
        w_q_next = {r_q[0], r_q[WIDTH-1:1]};
        w_ser    = r_q[0];
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_q    <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_q    <= w_q_next;
      r_wrap <= w_tc;
    end
  end

  assign q       = r_q;
  assign tc_out  = w_tc;
  assign ser_out = w_ser;
  assign wrap    = r_wrap;

endmodule

// File: tb/tb_universal_counter_reg.sv
// Self-checking bench: two 8-bit instances (full range and modulus 10) against an arithmetic
// reference model, plus a two-stage 4-bit cascade checked as one 8-bit counter.
module tb_universal_counter_reg;

  logic       clk;
  logic       rst;
  logic [2:0] mode;
  logic       cnt_en;
  logic [7:0] d;
  logic       ser_in;
  logic [7:0] q_a, q_b;
  logic       tc_a, tc_b, ser_a, ser_b, wrap_a, wrap_b;

  logic       c_rst;
  logic [2:0] c_mode;
  logic       c_en;
  logic [3:0] c_d0, c_d1;
  logic [3:0] c_q0, c_q1;
  logic       c_tc0, c_tc1, c_ser0, c_ser1, c_w0, c_w1;

  int total = 0;
  int bad   = 0;

  int m_qa, m_qb, m_wa, m_wb;

  universal_counter_reg #(.WIDTH(8), .MODULUS(0)) dut_a (
    .clk(clk), .rst(rst), .mode(mode), .cnt_en(cnt_en), .d(d), .ser_in(ser_in),
    .q(q_a), .tc_out(tc_a), .ser_out(ser_a), .wrap(wrap_a)
  );

  universal_counter_reg #(.WIDTH(8), .MODULUS(10)) dut_b (
    .clk(clk), .rst(rst), .mode(mode), .cnt_en(cnt_en), .d(d), .ser_in(ser_in),
    .q(q_b), .tc_out(tc_b), .ser_out(ser_b), .wrap(wrap_b)
  );

  universal_counter_reg #(.WIDTH(4), .MODULUS(0)) stage0 (
    .clk(clk), .rst(c_rst), .mode(c_mode), .cnt_en(c_en), .d(c_d0), .ser_in(1'b0),
    .q(c_q0), .tc_out(c_tc0), .ser_out(c_ser0), .wrap(c_w0)
  );

  universal_counter_reg #(.WIDTH(4), .MODULUS(0)) stage1 (
    .clk(clk), .rst(c_rst), .mode(c_mode), .cnt_en(c_tc0), .d(c_d1), .ser_in(1'b0),
    .q(c_q1), .tc_out(c_tc1), .ser_out(c_ser1), .wrap(c_w1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference rules for an 8-bit register with count ceiling mx.
  function automatic int m_next(int qv, int md, bit en, int dv, bit si, int mx);
    case (md)
      1:       return en ? ((qv >= mx) ? 0 : qv + 1) : qv;
      2:       return en ? ((qv == 0) ? mx : qv - 1) : qv;
      3:       return dv;
      4:       return (qv * 2 + si) % 256;
      5:       return qv / 2 + si * 128;
      6:       return (qv * 2) % 256 + qv / 128;
      7:       return qv / 2 + (qv % 2) * 128;
      default: return qv;
    endcase
  endfunction

  function automatic int m_tc(int qv, int md, bit en, int mx);
    if (md == 1) return (en && qv >= mx) ? 1 : 0;
    if (md == 2) return (en && qv == 0) ? 1 : 0;
    return 0;
  endfunction

  function automatic int m_ser(int qv, int md);
    if (md == 4 || md == 6) return qv / 128;
    if (md == 5 || md == 7) return qv % 2;
    return 0;
  endfunction

  // One clock of stimulus on the two 8-bit instances, checking combinational
  // outputs before the edge and registered outputs after it.
  task automatic cyc(input bit r, input int md, input bit en, input int dv, input bit si);
    int tca, tcb;
    rst    = r;
    mode   = 3'(md);
    cnt_en = en;
    d      = 8'(dv);
    ser_in = si;
    #1;
    tca = m_tc(m_qa, md, en, 255);
    tcb = m_tc(m_qb, md, en, 9);
    check("tc_a", 32'(tc_a), 32'(tca));
    check("tc_b", 32'(tc_b), 32'(tcb));
    check("ser_a", 32'(ser_a), 32'(m_ser(m_qa, md)));
    check("ser_b", 32'(ser_b), 32'(m_ser(m_qb, md)));
    if (r) begin
      m_qa = 0; m_qb = 0; m_wa = 0; m_wb = 0;
    end else begin
      m_qa = m_next(m_qa, md, en, dv, si, 255);
      m_qb = m_next(m_qb, md, en, dv, si, 9);
      m_wa = tca;
      m_wb = tcb;
    end
    @(posedge clk);
    #1;
    check("q_a", 32'(q_a), 32'(m_qa));
    check("q_b", 32'(q_b), 32'(m_qb));
    check("wrap_a", 32'(wrap_a), 32'(m_wa));
    check("wrap_b", 32'(wrap_b), 32'(m_wb));
  endtask

  initial begin
    int v;
    rst = 1'b1; mode = 3'd0; cnt_en = 1'b0; d = 8'd0; ser_in = 1'b0;
    c_rst = 1'b1; c_mode = 3'd0; c_en = 1'b0; c_d0 = 4'd0; c_d1 = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    m_qa = 0; m_qb = 0; m_wa = 0; m_wb = 0;
    check("rst_q_a", 32'(q_a), 32'h0);
    check("rst_wrap_a", 32'(wrap_a), 32'h0);

    // Reset in the middle of counting, and reset overriding a load.
    rst = 1'b0;
    repeat (5) cyc(0, 1, 1, 0, 0);
    check("up5_a", 32'(q_a), 32'h5);
    cyc(1, 1, 1, 0, 0);
    check("mid_rst_q", 32'(q_a), 32'h0);
    check("mid_rst_wrap", 32'(wrap_a), 32'h0);
    cyc(1, 3, 0, 8'hAA, 0);
    check("rst_over_load", 32'(q_a), 32'h0);

    // Full-range up wrap and count-enable hold.
    cyc(0, 3, 0, 8'hFE, 0);
    cyc(0, 1, 1, 0, 0);
    check("up_ff", 32'(q_a), 32'hFF);
    cyc(0, 1, 1, 0, 0);
    check("up_wrap_q", 32'(q_a), 32'h00);
    check("up_wrap_pulse", 32'(wrap_a), 32'h1);
    cyc(0, 1, 1, 0, 0);
    check("wrap_one_cycle", 32'(wrap_a), 32'h0);
    cyc(0, 1, 0, 0, 0);
    check("en_low_hold", 32'(q_a), 32'h01);

    // Modulus-10 down wrap, then out-of-range load wrapping on the next up count.
    cyc(0, 3, 0, 8'h01, 0);
    cyc(0, 2, 1, 0, 0);
    check("down_zero_b", 32'(q_b), 32'h0);
    cyc(0, 2, 1, 0, 0);
    check("down_wrap_b", 32'(q_b), 32'h9);
    check("down_wrap_pulse_b", 32'(wrap_b), 32'h1);
    cyc(0, 3, 0, 12, 0);
    cyc(0, 1, 1, 0, 0);
    check("over_max_wrap_b", 32'(q_b), 32'h0);

    // Shift and rotate.
    cyc(0, 3, 0, 8'h81, 0);
    cyc(0, 4, 0, 0, 0);
    check("shl", 32'(q_a), 32'h02);
    cyc(0, 3, 0, 8'h01, 0);
    cyc(0, 7, 0, 0, 0);
    check("ror", 32'(q_a), 32'h80);
    cyc(0, 3, 0, 8'h00, 0);
    cyc(0, 5, 0, 0, 1);
    check("shr_ser_in", 32'(q_a), 32'h80);

    // Mode churn between up and down, then load with count enable low.
    cyc(0, 3, 0, 5, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, (i % 2 == 0) ? 1 : 2, 1, 0, 0);
      check("churn", 32'(q_a), (i % 2 == 0) ? 32'h6 : 32'h5);
    end
    cyc(0, 3, 0, 8'h3C, 0);
    check("load_en_low", 32'(q_a), 32'h3C);

    // Randomised traffic with occasional reset.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 31) == 0), int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
          int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end

    // Cascade: stage0 carry feeds stage1 count enable.
    rst = 1'b1;
    c_rst = 1'b0; c_mode = 3'd3; c_d0 = 4'hF; c_d1 = 4'h0;
    @(posedge clk); #1;
    check("casc_load", {24'd0, c_q1, c_q0}, 32'h0F);
    c_mode = 3'd1; c_en = 1'b1;
    #1;
    check("casc_tc0", 32'(c_tc0), 32'h1);
    @(posedge clk); #1;
    check("casc_carry", {24'd0, c_q1, c_q0}, 32'h10);
    c_rst = 1'b1;
    @(posedge clk); #1;
    c_rst = 1'b0;
    v = 0;
    for (int i = 0; i < 256; i++) begin
      #1;
      check("casc_tc1", 32'(c_tc1), (v == 255) ? 32'h1 : 32'h0);
      @(posedge clk); #1;
      v = (v + 1) % 256;
      check("casc_q", {24'd0, c_q1, c_q0}, 32'(v));
    end
    check("casc_back_zero", {24'd0, c_q1, c_q0}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
